// File: rtl/seg7_reader.sv
// Recovers the hex digit from an active-low 7-segment bus once the pattern has
// been sampled identically for STABLE_CYCLES edges; flags blank and illegal patterns.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [6:0]       seg_in,
    input  logic             sample_en,
    output logic [3:0]       value,
    output logic             value_valid,
    output logic             invalid,
    output logic             blank,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg;
    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             same;
    logic             legal;
    logic             is_blank;
    logic [3:0]       digit;

    assign same     = (seg_in == seg_q);
    assign cnt_next = !same ? '0 : ((cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1);
    assign is_blank = (seg_in == 7'b1111111);

    // Segment order is {a,b,c,d,e,f,g}; a 0 bit means the segment is lit.
    always_comb begin
        legal = 1'b1;
        digit = 4'h0;
        case (seg_in)
            7'b0000001: digit = 4'h0;
            7'b1001111: digit = 4'h1;
            7'b0010010: digit = 4'h2;
            7'b0000110: digit = 4'h3;
            7'b1001100: digit = 4'h4;
            7'b0100100: digit = 4'h5;
            7'b0100000: digit = 4'h6;
            7'b0001101: digit = 4'h7;
            7'b0000000: digit = 4'h8;
            7'b0000100: digit = 4'h9;
            7'b0001000: digit = 4'hA;
            7'b1100000: digit = 4'hB;
            7'b0110001: digit = 4'hC;
            7'b1000010: digit = 4'hD;
            7'b0110000: digit = 4'hE;
            7'b0111000: digit = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg   <= IDLE;
            seg_q       <= 7'b1111111;
            cnt_reg     <= '0;
            value       <= 4'h0;
            value_valid <= 1'b0;
            invalid     <= 1'b0;
            blank       <= 1'b0;
            err_count   <= '0;
            locked      <= 1'b0;
        end else begin
            seg_q       <= seg_in;
            value_valid <= 1'b0;
            invalid     <= 1'b0;
            blank       <= 1'b0;
            if (!sample_en) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                locked    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Stability counting always starts fresh on (re)enable.
                        cnt_reg   <= '0;
                        locked    <= 1'b0;
                        state_reg <= TRACK;
                    end
                    TRACK: begin
                        cnt_reg <= cnt_next;
                        if (same && (cnt_reg == CNT_FIRE)) begin
                            if (legal) begin
                                value       <= digit;
                                value_valid <= 1'b1;
                            end else if (is_blank) begin
                                blank <= 1'b1;
                            end else begin
                                invalid <= 1'b1;
                                if (err_count != {ERR_W{1'b1}})
                                    err_count <= err_count + 1'b1;
                            end
                            state_reg <= LOCKED;
                            locked    <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        cnt_reg <= cnt_next;
                        if (!same) begin
                            state_reg <= TRACK;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: table sweep of legal/blank/invalid codes plus
// hand-written sequences for latency, glitch, saturation, enable and reset corners.
module tb_seg7_reader;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic [6:0] seg_in = 7'b1111111;
    logic       sample_en = 1'b0;
    logic [3:0] value;
    logic       value_valid;
    logic       invalid;
    logic       blank;
    logic [7:0] err_count;
    logic       locked;

    seg7_reader #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .seg_in      (seg_in),
        .sample_en   (sample_en),
        .value       (value),
        .value_valid (value_valid),
        .invalid     (invalid),
        .blank       (blank),
        .err_count   (err_count),
        .locked      (locked)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [6:0] seg;
        int         kind;   // 0 = legal digit, 1 = blank, 2 = invalid
        logic [3:0] val;
        int         err;
    } vec_t;

    vec_t tbl [18];
    logic [6:0] codes [16];

    int checks = 0;
    int errors = 0;
    int nv, ni, nb, edge_i, first_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic clr();
        nv = 0; ni = 0; nb = 0; edge_i = 0; first_edge = -1;
    endtask

    // One clock edge; outputs sampled 1 ns after it, pulses tallied.
    task automatic tick();
        int hot;
        @(posedge Clock);
        #1;
        edge_i++;
        if (value_valid === 1'b1) begin
            nv++;
            if (first_edge < 0) first_edge = edge_i;
        end
        if (invalid === 1'b1) ni++;
        if (blank === 1'b1) nb++;
        hot = int'(value_valid === 1'b1) + int'(invalid === 1'b1) + int'(blank === 1'b1);
        checks++;
        if (hot > 1) begin
            errors++;
            $display("FAIL onehot_pulses actual=%0d expected<=1 at t=%0t", hot, $time);
        end
    endtask

    initial begin
        codes = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int i = 0; i < 16; i++) tbl[i] = '{codes[i], 0, 4'(i), 0};
        tbl[16] = '{7'b1111111, 1, 4'hF, 0};
        tbl[17] = '{7'b0111111, 2, 4'hF, 1};

        // Reset state
        #2 Resetn = 1'b0;
        #2;
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_invalid", invalid, 0);
        check("rst_blank", blank, 0);
        check("rst_err", err_count, 0);
        check("rst_locked", locked, 0);

        // First decode: pattern 2 held 10 edges after release
        sample_en = 1'b1;
        seg_in    = 7'b0010010;
        @(posedge Clock);
        #1 Resetn = 1'b1;
        clr();
        repeat (10) tick();
        check("first_pulse_edge", first_edge, 4);
        check("first_pulse_count", nv, 1);
        check("first_value", value, 2);
        check("first_locked", locked, 1);
        check("first_other_pulses", ni + nb, 0);

        // Table sweep: 16 legal codes, blank, invalid
        for (int i = 0; i < 18; i++) begin
            seg_in = tbl[i].seg;
            clr();
            repeat (6) tick();
            check($sformatf("tbl%0d_valid", i), nv, (tbl[i].kind == 0) ? 1 : 0);
            check($sformatf("tbl%0d_blank", i), nb, (tbl[i].kind == 1) ? 1 : 0);
            check($sformatf("tbl%0d_invalid", i), ni, (tbl[i].kind == 2) ? 1 : 0);
            check($sformatf("tbl%0d_edge", i), first_edge, (tbl[i].kind == 0) ? 4 : -1);
            check($sformatf("tbl%0d_value", i), value, tbl[i].val);
            check($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
            check($sformatf("tbl%0d_locked", i), locked, 1);
        end

        // Glitch: 3 stable, 2-cycle excursion to 1, back to 3
        seg_in = 7'b0000110;
        clr();
        repeat (6) tick();
        check("glitch_pre_value", value, 3);
        seg_in = 7'b1001111;
        clr();
        repeat (2) tick();
        check("glitch_no_pulse", nv + ni + nb, 0);
        check("glitch_unlocked", locked, 0);
        seg_in = 7'b0000110;
        clr();
        repeat (6) tick();
        check("glitch_ret_pulse", nv, 1);
        check("glitch_ret_edge", first_edge, 4);
        check("glitch_ret_value", value, 3);

        // Saturation: 300 invalid patterns, 5 edges each
        clr();
        for (int k = 0; k < 300; k++) begin
            seg_in = (k % 2 == 0) ? 7'b0111111 : 7'b1011111;
            repeat (5) tick();
            if (k == 253) check("sat_err_at_254", err_count, 255);
        end
        check("sat_invalid_pulses", ni, 300);
        check("sat_err_final", err_count, 255);
        check("sat_value_held", value, 3);

        // Drop sample_en with cnt=2 in TRACK, then reassert
        seg_in = 7'b0000000;
        clr();
        repeat (3) tick();
        check("en_track_no_pulse", nv, 0);
        sample_en = 1'b0;
        tick();
        check("en_drop_no_pulse", nv, 0);
        check("en_drop_locked", locked, 0);
        repeat (3) tick();
        check("en_idle_no_pulse", nv + ni + nb, 0);
        check("en_idle_value_held", value, 3);
        check("en_idle_err_held", err_count, 255);
        sample_en = 1'b1;
        clr();
        repeat (6) tick();
        check("en_re_pulse_edge", first_edge, 4);
        check("en_re_pulse_count", nv, 1);
        check("en_re_value", value, 8);
        check("en_re_locked", locked, 1);

        // Asynchronous reset mid-LOCKED
        #2 Resetn = 1'b0;
        #1;
        check("mid_rst_value", value, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_pulses", int'(value_valid) + int'(invalid) + int'(blank), 0);
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
        clr();
        repeat (6) tick();
        check("post_rst_pulse_edge", first_edge, 4);
        check("post_rst_pulse_count", nv, 1);
        check("post_rst_value", value, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
